// File: rtl/palette_fetch_arbiter.sv
// Palette fetch arbiter.
// Shares one 16-entry sprite palette LUT between NUM_REQ renderers.
// Arbitration is round-robin, and a winner may keep the LUT for up to
// BURST_LEN consecutive fetches. A two-stage pipeline returns the
// registered colour, the owning requester ID and a colour-key flag.
module palette_fetch_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int IDX_W     = 4,
  parameter int KEY_IDX   = 0,
  parameter int BURST_LEN = 4
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [IDX_W-1:0]           pal_index,
  input  logic [3:0]                 pal_red,
  input  logic [3:0]                 pal_green,
  input  logic [3:0]                 pal_blue,
  output logic                       rgb_valid,
  output logic [$clog2(NUM_REQ)-1:0] rgb_id,
  output logic [3:0]                 red,
  output logic [3:0]                 green,
  output logic [3:0]                 blue,
  output logic                       transparent
);

  localparam int              ID_W    = $clog2(NUM_REQ);
  localparam int              CNT_W   = $clog2(BURST_LEN + 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [ID_W-1:0]  owner, owner_next;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_next;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_next;

  logic [ID_W-1:0]  owner_inc;
  logic [ID_W-1:0]  scan_base;
  logic [ID_W-1:0]  scan_winner;
  logic             scan_found;
  logic             keep;
  logic             grant;
  logic [ID_W-1:0]  winner;
  logic [IDX_W-1:0] win_idx;

  logic             s1_valid;
  logic [ID_W-1:0]  s1_id;
  logic             s1_key;

  // The requester after the current owner, wrapping at NUM_REQ.
  assign owner_inc = (owner == LAST_ID) ? '0 : owner + 1'b1;

  // The owner keeps the LUT while it still asks and its burst has room.
  assign keep = (state == BURST) && req[owner] && (burst_cnt < CNT_W'(BURST_LEN));

  // A burst that ends arbitrates from owner+1; an idle arbiter starts at rr_ptr.
  assign scan_base = (state == BURST) ? owner_inc : rr_ptr;

  // Round-robin search: first set req at or after scan_base, wrapping.
  always_comb begin
    logic [ID_W:0] cand;
    // NOTE: every combinational output gets a default before any branch,
    // otherwise a path that skips the assignment infers a latch.
    cand        = '0;
    scan_found  = 1'b0;
    scan_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, scan_base} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(NUM_REQ)) cand = cand - (ID_W + 1)'(NUM_REQ);
      if (!scan_found && req[cand[ID_W-1:0]]) begin
        scan_found  = 1'b1;
        scan_winner = cand[ID_W-1:0];
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      state     <= state_next;
      owner     <= owner_next;
      rr_ptr    <= rr_ptr_next;
      burst_cnt <= burst_cnt_next;
    end
  end

  // Next-state decision: continue the burst, or end it and re-arbitrate.
  always_comb begin
    state_next     = state;
    owner_next     = owner;
    rr_ptr_next    = rr_ptr;
    burst_cnt_next = burst_cnt;
    grant          = 1'b0;
    winner         = owner;
    if (keep) begin
      grant          = 1'b1;
      burst_cnt_next = burst_cnt + CNT_W'(1);
    end else begin
      if (state == BURST) rr_ptr_next = owner_inc;
      if (scan_found) begin
        grant          = 1'b1;
        winner         = scan_winner;
        owner_next     = scan_winner;
        burst_cnt_next = CNT_W'(1);
        state_next     = BURST;
      end else begin
        state_next     = IDLE;
        burst_cnt_next = '0;
      end
    end
  end

  // One-hot grant, forced low while reset is asserted.
  always_comb begin
    gnt = '0;
    if (Reset_n && grant) gnt[winner] = 1'b1;
  end

  // Select the winning requester's palette index.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) win_idx = idx[i*IDX_W +: IDX_W];
    end
  end

  // Stage 1: launch the LUT index on the grant edge; hold it otherwise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pal_index <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_key    <= 1'b0;
    end else begin
      s1_valid <= grant;
      if (grant) begin
        pal_index <= win_idx;
        s1_id     <= winner;
        s1_key    <= (win_idx == IDX_W'(KEY_IDX));
      end
    end
  end

  // Stage 2: capture the LUT colour; colour, ID and key hold on bubbles.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_valid   <= 1'b0;
      rgb_id      <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      transparent <= 1'b0;
    end else begin
      rgb_valid <= s1_valid;
      if (s1_valid) begin
        rgb_id      <= s1_id;
        red         <= pal_red;
        green       <= pal_green;
        blue        <= pal_blue;
        transparent <= s1_key;
      end
    end
  end

endmodule

// File: tb/tb_palette_fetch_arbiter.sv
// Self-checking bench for palette_fetch_arbiter: directed scenarios followed
// by randomized request/index traffic, compared against a transaction model.
module tb_palette_fetch_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int IDX_W     = 4;
  localparam int KEY_IDX   = 0;
  localparam int BURST_LEN = 4;
  localparam int ID_W      = $clog2(NUM_REQ);

  logic                     Clk = 1'b0;
  logic                     Reset_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*IDX_W-1:0] idx;
  logic [NUM_REQ-1:0]       gnt;
  logic [IDX_W-1:0]         pal_index;
  logic [3:0]               pal_red, pal_green, pal_blue;
  logic                     rgb_valid;
  logic [ID_W-1:0]          rgb_id;
  logic [3:0]               red, green, blue;
  logic                     transparent;

  int checks = 0;
  int errors = 0;

  // Reference model state: last winner, length of its current run (0 = idle),
  // the fetch in flight, and the colour currently presented.
  int               m_last;
  int               m_run;
  logic             m_s1_valid;
  int               m_s1_id;
  logic [IDX_W-1:0] m_s1_idx;
  logic             m_out_valid;
  int               m_out_id;
  logic [11:0]      m_rgb;
  logic             m_trans;
  logic [IDX_W-1:0] m_pal_index;

  palette_fetch_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .IDX_W    (IDX_W),
    .KEY_IDX  (KEY_IDX),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req        (req),
    .idx        (idx),
    .gnt        (gnt),
    .pal_index  (pal_index),
    .pal_red    (pal_red),
    .pal_green  (pal_green),
    .pal_blue   (pal_blue),
    .rgb_valid  (rgb_valid),
    .rgb_id     (rgb_id),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .transparent(transparent)
  );

  always #5 Clk = ~Clk;

  // Palette contents: key entry is magenta, entry 5 is D1B, the rest distinct.
  function automatic logic [11:0] lut_rgb(input logic [3:0] i);
    case (i)
      4'h0:    return 12'hF0F;
      4'h5:    return 12'hD1B;
      default: return {i, ~i, i ^ 4'h3};
    endcase
  endfunction

  assign {pal_red, pal_green, pal_blue} = lut_rgb(pal_index);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last      = NUM_REQ - 1;
    m_run       = 0;
    m_s1_valid  = 1'b0;
    m_s1_id     = 0;
    m_s1_idx    = '0;
    m_out_valid = 1'b0;
    m_out_id    = 0;
    m_rgb       = '0;
    m_trans     = 1'b0;
    m_pal_index = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},       gnt,                {NUM_REQ{1'b0}});
    check({tag, "_valid"},     rgb_valid,          1'b0);
    check({tag, "_rgb"},       {red, green, blue}, 12'h000);
    check({tag, "_id"},        rgb_id,             0);
    check({tag, "_transp"},    transparent,        1'b0);
    check({tag, "_pal_index"}, pal_index,          0);
  endtask

  // One clock: drive inputs after the edge, check mid-cycle, then advance model.
  task automatic step(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*IDX_W-1:0] ix);
    int   w;
    logic g;
    int   exp_gnt;
    @(posedge Clk);
    #1;
    req = r;
    idx = ix;
    @(negedge Clk);
    check("rgb_valid",   rgb_valid,          m_out_valid);
    check("rgb_id",      rgb_id,             m_out_id);
    check("rgb",         {red, green, blue}, m_rgb);
    check("transparent", transparent,        m_trans);
    check("pal_index",   pal_index,          m_pal_index);

    g = 1'b0;
    w = m_last;
    if (m_run > 0 && r[m_last] && m_run < BURST_LEN) begin
      g = 1'b1;
      m_run++;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_last + k) % NUM_REQ;
        if (!g && r[c]) begin
          g = 1'b1;
          w = c;
        end
      end
      if (g) begin
        m_last = w;
        m_run  = 1;
      end else begin
        m_run = 0;
      end
    end
    exp_gnt = g ? (1 << w) : 0;
    check("gnt", gnt, exp_gnt);

    if (m_s1_valid) begin
      m_rgb    = lut_rgb(m_s1_idx);
      m_out_id = m_s1_id;
      m_trans  = (m_s1_idx == KEY_IDX);
    end
    m_out_valid = m_s1_valid;
    m_s1_valid  = g;
    if (g) begin
      m_s1_id     = w;
      m_s1_idx    = ix[w*IDX_W +: IDX_W];
      m_pal_index = m_s1_idx;
    end
  endtask

  // Asynchronous reset asserted between clock edges, released on a falling edge.
  task automatic pulse_reset(input string tag);
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    req     = '1;
    #1;
    model_reset();
    check_reset_outputs(tag);
    req = '0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic random_steps(input int n);
    logic [NUM_REQ-1:0]       r;
    logic [NUM_REQ*IDX_W-1:0] ix;
    for (int s = 0; s < n; s++) begin
      for (int b = 0; b < NUM_REQ; b++) begin
        r[b] = ($urandom_range(3, 0) != 0);
        ix[b*IDX_W +: IDX_W] = IDX_W'($urandom_range(15, 0));
      end
      step(r, ix);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    req     = '1;
    idx     = '0;
    model_reset();
    #2;
    check_reset_outputs("init");
    req = '0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Single requester 0, index 5: colour D1B two cycles later.
    step(2'b01, 8'h05);
    step(2'b00, 8'h00);
    step(2'b00, 8'h00);
    // Requester 1 fetching the colour key: magenta, flagged transparent.
    step(2'b10, 8'h03);
    step(2'b00, 8'h00);
    step(2'b00, 8'h00);
    // Both requesting: bursts of BURST_LEN alternate between requesters.
    for (int s = 0; s < 20; s++) step(2'b11, 8'(16 * ((s + 2) % 16) + (s % 16)));
    // Idle: grants stop, valid drops, colour and pal_index hold.
    for (int s = 0; s < 10; s++) step(2'b00, 8'hA7);

    // Reset during a stream.
    for (int s = 0; s < 3; s++) step(2'b11, 8'h9C);
    pulse_reset("mid");
    // Requester 0 first after reset; it drops after two grants, then 1 bursts.
    step(2'b11, 8'h21);
    step(2'b11, 8'h43);
    step(2'b10, 8'h65);
    for (int s = 0; s < 8; s++) step(2'b11, 8'(8'h87 + s));
    for (int s = 0; s < 3; s++) step(2'b00, 8'h00);

    random_steps(300);
    pulse_reset("rand");
    random_steps(200);
    for (int s = 0; s < 3; s++) step(2'b00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
